// File: rtl/nvram_backup_sequencer.sv
// HPS-side port B controller for the NVRAM: streams a full backup image after a CPU quiet
// period or on request, and writes a full restore image back while CPU access is gated.
module nvram_backup_sequencer #(
  parameter int ADDR_W       = 13,
  parameter int QUIET_CYCLES = 30000000,
  parameter int TMR_W        = 25
) (
  input  logic              clk30,
  input  logic              reset,
  input  logic              cpu_write_pulse,
  input  logic              force_backup,
  input  logic              restore_req,
  input  logic              restore_valid,
  input  logic [7:0]        restore_data,
  output logic [ADDR_W-1:0] nvram_adr,
  output logic [7:0]        nvram_wdata,
  output logic              nvram_we,
  input  logic [7:0]        nvram_rdata,
  output logic              backup_valid,
  output logic [ADDR_W-1:0] backup_adr,
  output logic [7:0]        backup_data,
  input  logic              backup_ready,
  output logic              allow_cpu_access,
  output logic              dirty,
  output logic              busy,
  output logic              backup_done,
  output logic              restore_done
);

  typedef enum logic [1:0] {IDLE, RESTORE, BK_READ, BK_PRESENT} state_t;

  localparam logic [ADDR_W-1:0] ADR_MAX = '1;
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(QUIET_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] adr, adr_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              dirty_nxt;
  logic              backup_done_nxt, restore_done_nxt;
  logic              loaded;
  logic [7:0]        data_hold;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    return (t == TMR_MAX) ? t : t + TMR_W'(1);
  endfunction

  always_comb begin
    state_nxt        = state;
    adr_nxt          = adr;
    dirty_nxt        = dirty;
    timer_nxt        = timer;
    backup_done_nxt  = 1'b0;
    restore_done_nxt = 1'b0;

    // A restore overwrites the whole image, so CPU writes seen during it are not tracked.
    if (state != RESTORE) begin
      if (cpu_write_pulse) begin
        dirty_nxt = 1'b1;
        timer_nxt = '0;
      end else if (dirty && state == IDLE) begin
        timer_nxt = sat_inc(timer);
      end
    end

    case (state)
      IDLE: begin
        if (restore_req) begin
          state_nxt = RESTORE;
          adr_nxt   = '0;
        end else if (force_backup || (dirty && timer == TMR_MAX && !cpu_write_pulse)) begin
          state_nxt = BK_READ;
          adr_nxt   = '0;
          dirty_nxt = cpu_write_pulse;
          timer_nxt = '0;
        end
      end
      RESTORE: begin
        if (restore_valid) begin
          adr_nxt = adr + ADDR_W'(1);
          if (adr == ADR_MAX) begin
            state_nxt        = IDLE;
            restore_done_nxt = 1'b1;
            dirty_nxt        = 1'b0;
            timer_nxt        = '0;
          end
        end
      end
      BK_READ: begin
        if (restore_req) begin
          state_nxt = RESTORE;
          adr_nxt   = '0;
        end else begin
          state_nxt = BK_PRESENT;
        end
      end
      BK_PRESENT: begin
        if (restore_req) begin
          state_nxt = RESTORE;
          adr_nxt   = '0;
        end else if (backup_ready) begin
          if (adr == ADR_MAX) begin
            state_nxt       = IDLE;
            adr_nxt         = '0;
            backup_done_nxt = 1'b1;
          end else begin
            state_nxt = BK_READ;
            adr_nxt   = adr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      state        <= IDLE;
      adr          <= '0;
      dirty        <= 1'b0;
      timer        <= '0;
      backup_done  <= 1'b0;
      restore_done <= 1'b0;
      loaded       <= 1'b0;
    end else begin
      state        <= state_nxt;
      adr          <= adr_nxt;
      dirty        <= dirty_nxt;
      timer        <= timer_nxt;
      backup_done  <= backup_done_nxt;
      restore_done <= restore_done_nxt;
      loaded       <= (state == BK_PRESENT);
    end
  end

  // RAM output is first valid in the opening BK_PRESENT cycle; hold it while HPS stalls.
  always_ff @(posedge clk30) begin
    if (state == BK_PRESENT && !loaded)
      data_hold <= nvram_rdata;
  end

  assign nvram_adr        = adr;
  assign nvram_wdata      = restore_data;
  assign nvram_we         = (state == RESTORE) && restore_valid;
  assign backup_valid     = (state == BK_PRESENT);
  assign backup_adr       = adr;
  assign backup_data      = loaded ? data_hold : nvram_rdata;
  assign allow_cpu_access = (state != RESTORE);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_nvram_backup_sequencer.sv
// Scoreboard bench for nvram_backup_sequencer with a small port-B RAM model.
module tb_nvram_backup_sequencer;
  localparam int AW = 4;
  localparam int QC = 16;
  localparam int TW = 5;

  logic          clk30 = 1'b0;
  logic          reset, cpu_write_pulse, force_backup, restore_req, restore_valid;
  logic [7:0]    restore_data;
  logic [AW-1:0] nvram_adr;
  logic [7:0]    nvram_wdata;
  logic          nvram_we;
  logic [7:0]    nvram_rdata;
  logic          backup_valid;
  logic [AW-1:0] backup_adr;
  logic [7:0]    backup_data;
  logic          backup_ready;
  logic          allow_cpu_access, dirty, busy, backup_done, restore_done;

  always #5 clk30 = ~clk30;

  nvram_backup_sequencer #(.ADDR_W(AW), .QUIET_CYCLES(QC), .TMR_W(TW)) dut (
    .clk30(clk30), .reset(reset), .cpu_write_pulse(cpu_write_pulse),
    .force_backup(force_backup), .restore_req(restore_req),
    .restore_valid(restore_valid), .restore_data(restore_data),
    .nvram_adr(nvram_adr), .nvram_wdata(nvram_wdata), .nvram_we(nvram_we),
    .nvram_rdata(nvram_rdata), .backup_valid(backup_valid), .backup_adr(backup_adr),
    .backup_data(backup_data), .backup_ready(backup_ready),
    .allow_cpu_access(allow_cpu_access), .dirty(dirty), .busy(busy),
    .backup_done(backup_done), .restore_done(restore_done)
  );

  // Dual-port RAM model: port A is the bench preload path, port B is the DUT.
  logic [7:0]    mem [16];
  logic          pa_we;
  logic [AW-1:0] pa_adr;
  logic [7:0]    pa_wdata;
  always @(posedge clk30) begin
    if (pa_we) mem[pa_adr] <= pa_wdata;
    else if (nvram_we) mem[nvram_adr] <= nvram_wdata;
    nvram_rdata <= mem[nvram_adr];
  end

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [7:0]    data;
  } bk_t;

  bk_t        bk_q[$];
  logic [7:0] exp_ram [16];
  int         vectors = 0;
  int         miscompares = 0;
  int         bk_done_cnt = 0;
  int         rs_done_cnt = 0;
  int         exp_bk_done = 0;
  logic       rdy_toggle = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk30) begin
    if (!reset) begin
      if (backup_done || restore_done)
        check_val("done_excl", 32'(backup_done && restore_done), 32'd0);
      if (backup_done) bk_done_cnt++;
      if (restore_done) rs_done_cnt++;
      if (backup_valid) begin
        if (bk_q.size() == 0) begin
          check_val("bk_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("bk_adr", 32'(backup_adr), 32'(bk_q[0].adr));
          check_val("bk_data", 32'(backup_data), 32'(bk_q[0].data));
          if (backup_ready && !restore_req) void'(bk_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk30);
    #1;
    if (rdy_toggle) backup_ready = ~backup_ready;
  endtask

  task automatic push_image();
    for (int i = 0; i < 16; i++) bk_q.push_back('{adr: AW'(i), data: exp_ram[i]});
  endtask

  task automatic pulse_force();
    force_backup = 1'b1;
    tick();
    force_backup = 1'b0;
  endtask

  task automatic wait_bk_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!backup_done && n < 400);
    check_val(tag, 32'(backup_done), 32'd1);
    exp_bk_done++;
    tick();
    check_val({tag, "_cnt"}, 32'(bk_done_cnt), 32'(exp_bk_done));
    check_val({tag, "_qempty"}, 32'(bk_q.size()), 32'd0);
  endtask

  task automatic measure_quiet(input string tag);
    int n;
    n = 0;
    while (!busy && n < 64) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n), 32'd16);
    check_val({tag, "_bkread"}, 32'(backup_valid), 32'd0);
    check_val({tag, "_dirty_clr"}, 32'(dirty), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    reset = 1'b1; cpu_write_pulse = 1'b0; force_backup = 1'b0; restore_req = 1'b0;
    restore_valid = 1'b0; restore_data = '0; backup_ready = 1'b1;
    pa_we = 1'b0; pa_adr = '0; pa_wdata = '0;
    repeat (3) tick();
    check_val("rst_adr", 32'(nvram_adr), 32'd0);
    check_val("rst_we", 32'(nvram_we), 32'd0);
    check_val("rst_bvalid", 32'(backup_valid), 32'd0);
    check_val("rst_dirty", 32'(dirty), 32'd0);
    check_val("rst_allow", 32'(allow_cpu_access), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dones", 32'({backup_done, restore_done}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pa_we = 1'b1; pa_adr = AW'(i); pa_wdata = 8'(i) ^ 8'h5A; exp_ram[i] = 8'(i) ^ 8'h5A;
      tick();
    end
    pa_we = 1'b0;
    tick();
    check_val("preload_idle", 32'({busy, dirty}), 32'd0);

    // Single write, automatic backup after the quiet period.
    cpu_write_pulse = 1'b1;
    tick();
    cpu_write_pulse = 1'b0;
    check_val("t1_dirty_set", 32'(dirty), 32'd1);
    check_val("t1_not_busy", 32'(busy), 32'd0);
    push_image();
    measure_quiet("t1_quiet");
    wait_bk_done("t1_done");
    check_val("t1_dirty_end", 32'(dirty), 32'd0);

    // Writes every 10 cycles hold the backup off.
    for (int w = 0; w < 10; w++) begin
      cpu_write_pulse = 1'b1;
      tick();
      cpu_write_pulse = 1'b0;
      if (w < 9) begin
        repeat (9) begin
          tick();
          check_val("t2_no_backup", 32'(busy), 32'd0);
        end
      end
    end
    push_image();
    measure_quiet("t2_quiet");
    wait_bk_done("t2_done");

    // Backpressure: ready toggles every cycle.
    rdy_toggle = 1'b1;
    push_image();
    pulse_force();
    wait_bk_done("t3_done");
    rdy_toggle = 1'b0;
    backup_ready = 1'b1;
    check_val("t3_dirty", 32'(dirty), 32'd0);

    // Restore with 3-cycle gaps, stray CPU write and stray restore_req.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check_val("t4_gate", 32'(allow_cpu_access), 32'd0);
    check_val("t4_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_ram[i] = b;
      restore_valid = 1'b1; restore_data = b;
      tick();
      restore_valid = 1'b0;
      if (i < 15) begin
        check_val("t4_gate_mid", 32'(allow_cpu_access), 32'd0);
        check_val("t4_no_done", 32'(restore_done), 32'd0);
        repeat (3) begin
          cpu_write_pulse = (i == 4);
          restore_req = (i == 8);
          tick();
          cpu_write_pulse = 1'b0;
          restore_req = 1'b0;
          check_val("t4_gate_gap", 32'(allow_cpu_access), 32'd0);
        end
      end else begin
        check_val("t4_done", 32'(restore_done), 32'd1);
        check_val("t4_ungated", 32'(allow_cpu_access), 32'd1);
      end
    end
    check_val("t4_dirty", 32'(dirty), 32'd0);
    tick();
    check_val("t4_rs_cnt", 32'(rs_done_cnt), 32'd1);
    push_image();
    pulse_force();
    wait_bk_done("t4_verify");

    // Abort a backup at byte 5 with a restore.
    push_image();
    pulse_force();
    n = 0;
    while (!(backup_valid && backup_adr == AW'(5)) && n < 100) begin
      tick();
      n++;
    end
    check_val("t5_reach", 32'(backup_adr), 32'd5);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check_val("t5_valid_drop", 32'(backup_valid), 32'd0);
    check_val("t5_gate", 32'(allow_cpu_access), 32'd0);
    check_val("t5_remaining", 32'(bk_q.size()), 32'd11);
    bk_q.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_ram[i] = b;
      restore_valid = 1'b1; restore_data = b;
      tick();
    end
    restore_valid = 1'b0;
    check_val("t5_rs_done", 32'(restore_done), 32'd1);
    tick();
    check_val("t5_no_bk_done", 32'(bk_done_cnt), 32'(exp_bk_done));
    check_val("t5_rs_cnt", 32'(rs_done_cnt), 32'd2);
    push_image();
    pulse_force();
    wait_bk_done("t5_verify");

    // Reset in the middle of a restore.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom);
      exp_ram[i] = b;
      restore_valid = 1'b1; restore_data = b;
      tick();
    end
    restore_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_val("t6_idle", 32'(busy), 32'd0);
    check_val("t6_allow", 32'(allow_cpu_access), 32'd1);
    check_val("t6_adr", 32'(nvram_adr), 32'd0);
    restore_valid = 1'b1;
    #1;
    check_val("t6_we", 32'(nvram_we), 32'd0);
    restore_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_val("t6_rs_cnt", 32'(rs_done_cnt), 32'd2);
    push_image();
    pulse_force();
    wait_bk_done("t6_verify");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
